// File: rtl/dqs_seq_pkg.sv
// Shared types, constants and slot-mask helpers for the DQS write sequencer.
package dqs_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2,
        POST  = 2'd3
    } state_e;

    localparam logic [7:0] DQS_TOGGLE = 8'b0101_0101;
    localparam logic [3:0] OEN_ALL    = 4'b1111;

    // Slot 0 is first in time, so the preamble occupies the MSB (latest) slots.
    function automatic logic [3:0] pre_mask(input int n);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= 4 - n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [3:0] post_mask(input int n);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/dqs_wr_seq_if.sv
// Request/abort handshake from the write scheduler and gearbox-side DQS outputs.
interface dqs_wr_seq_if #(parameter int LEN_W = 6);

    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    logic             flush;
    logic [3:0]       t;
    logic [7:0]       d;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_len, flush,
        input  req_ready, t, d, busy, done
    );

    modport slave (
        input  req_valid, req_len, flush,
        output req_ready, t, d, busy, done
    );

endinterface

// File: rtl/dqs_wr_seq.sv
// DQS write-burst sequencer: preamble, toggle train with back-to-back merge,
// postamble, feeding the t1..t4 / d1..d8 gearbox inputs of the DQS pad.
module dqs_wr_seq
    import dqs_seq_pkg::*;
#(
    parameter int LEN_W      = 6,
    parameter int PRE_SLOTS  = 1,
    parameter int POST_SLOTS = 1
) (
    input  logic         gsclk_ol,
    input  logic         rst_n,
    dqs_wr_seq_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_PRE   = 2'(PRE);
    localparam logic [1:0] ST_BURST = 2'(BURST);
    localparam logic [1:0] ST_POST  = 2'(POST);

    localparam logic [3:0] PRE_T  = pre_mask(PRE_SLOTS);
    localparam logic [3:0] POST_T = post_mask(POST_SLOTS);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [3:0]       t_q, t_d;
    logic [7:0]       d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             req_ready;
    logic             accept;
    logic [LEN_W-1:0] len_m1;

    // cnt holds the number of BURST beats still to follow the current one;
    // a merge is only possible once it has run down to zero.
    always_comb begin
        req_ready = !bus.flush &&
                    (state_q == ST_IDLE || state_q == ST_POST ||
                     (state_q == ST_BURST && cnt_q == '0));
        accept    = bus.req_valid && req_ready;
        len_m1    = (bus.req_len == '0) ? '0 : bus.req_len - LEN_W'(1);

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = len_m1;
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                state_d = bus.flush ? ST_POST : ST_BURST;
            end
            ST_BURST: begin
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = ST_POST;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (accept) begin
                    cnt_d = len_m1;
                end else begin
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                if (accept) begin
                    cnt_d   = len_m1;
                    state_d = ST_PRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the pad sees registered values.
    always_comb begin
        t_d    = 4'b0000;
        d_d    = 8'h00;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_POST);
        case (state_d)
            ST_PRE:   t_d = PRE_T;
            ST_BURST: begin
                t_d = OEN_ALL;
                d_d = DQS_TOGGLE;
            end
            ST_POST:  t_d = POST_T;
            default:  t_d = 4'b0000;
        endcase
    end

    always_ff @(posedge gsclk_ol or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            t_q     <= 4'b0000;
            d_q     <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.t         = t_q;
    assign bus.d         = d_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dqs_wr_seq.sv
// Directed self-checking bench for dqs_wr_seq: default 1/1 slot instance plus a 2/2 slot instance.
module tb_dqs_wr_seq;

    logic clk;
    logic rst1_n;
    logic rst2_n;
    int   assertCount;
    int   failCount;
    int   burstBeats;
    int   doneCount;

    dqs_wr_seq_if #(.LEN_W(6)) if1 ();
    dqs_wr_seq_if #(.LEN_W(6)) if2 ();

    dqs_wr_seq #(.LEN_W(6), .PRE_SLOTS(1), .POST_SLOTS(1)) dut1 (
        .gsclk_ol (clk),
        .rst_n    (rst1_n),
        .bus      (if1.slave)
    );

    dqs_wr_seq #(.LEN_W(6), .PRE_SLOTS(2), .POST_SLOTS(2)) dut2 (
        .gsclk_ol (clk),
        .rst_n    (rst2_n),
        .bus      (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [5:0] len, input logic fl);
        if1.req_valid = valid;
        if1.req_len   = len;
        if1.flush     = fl;
    endtask

    // Advance one gsclk_ol edge and sample 1 ns later; count dut1 BURST and POST beats.
    task automatic tick();
        @(posedge clk);
        #1;
        if (if1.t === 4'hF) burstBeats++;
        if (if1.done === 1'b1) doneCount++;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        burstBeats  = 0;
        doneCount   = 0;
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        applyStimulus(1'b0, 6'd0, 1'b0);
        if2.req_valid = 1'b0;
        if2.req_len   = 6'd0;
        if2.flush     = 1'b0;
        #12;
        checkOutput("rst_t", 32'(if1.t), 32'h0);
        checkOutput("rst_d", 32'(if1.d), 32'h00);
        checkOutput("rst_busy", 32'(if1.busy), 32'h0);
        checkOutput("rst_done", 32'(if1.done), 32'h0);
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        #1;
        checkOutput("idle_ready", 32'(if1.req_ready), 32'h1);

        // Single burst: 1000, 1111, 0001, 0000
        applyStimulus(1'b1, 6'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("s1_pre_t", 32'(if1.t), 32'h8);
        checkOutput("s1_pre_d", 32'(if1.d), 32'h00);
        checkOutput("s1_pre_busy", 32'(if1.busy), 32'h1);
        checkOutput("s1_pre_done", 32'(if1.done), 32'h0);
        tick();
        checkOutput("s1_burst_t", 32'(if1.t), 32'hF);
        checkOutput("s1_burst_d", 32'(if1.d), 32'h55);
        checkOutput("s1_burst_ready", 32'(if1.req_ready), 32'h1);
        tick();
        checkOutput("s1_post_t", 32'(if1.t), 32'h1);
        checkOutput("s1_post_d", 32'(if1.d), 32'h00);
        checkOutput("s1_post_done", 32'(if1.done), 32'h1);
        checkOutput("s1_post_busy", 32'(if1.busy), 32'h1);
        tick();
        checkOutput("s1_idle_t", 32'(if1.t), 32'h0);
        checkOutput("s1_idle_busy", 32'(if1.busy), 32'h0);
        checkOutput("s1_idle_done", 32'(if1.done), 32'h0);

        // Three bursts: ready only in the third BURST beat
        applyStimulus(1'b1, 6'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("s3_pre_t", 32'(if1.t), 32'h8);
        tick();
        checkOutput("s3_b1_t", 32'(if1.t), 32'hF);
        checkOutput("s3_b1_ready", 32'(if1.req_ready), 32'h0);
        tick();
        checkOutput("s3_b2_d", 32'(if1.d), 32'h55);
        checkOutput("s3_b2_ready", 32'(if1.req_ready), 32'h0);
        tick();
        checkOutput("s3_b3_t", 32'(if1.t), 32'hF);
        checkOutput("s3_b3_ready", 32'(if1.req_ready), 32'h1);
        tick();
        checkOutput("s3_post_t", 32'(if1.t), 32'h1);
        tick();
        checkOutput("s3_idle_t", 32'(if1.t), 32'h0);

        // Merge: len 2 then len 1 in the last BURST beat
        burstBeats = 0;
        doneCount  = 0;
        applyStimulus(1'b1, 6'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        tick();
        tick();
        checkOutput("mg_b2_ready", 32'(if1.req_ready), 32'h1);
        applyStimulus(1'b1, 6'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("mg_b3_t", 32'(if1.t), 32'hF);
        checkOutput("mg_b3_d", 32'(if1.d), 32'h55);
        tick();
        checkOutput("mg_post_t", 32'(if1.t), 32'h1);
        tick();
        checkOutput("mg_idle_t", 32'(if1.t), 32'h0);
        checkOutput("mg_beats", 32'(burstBeats), 32'd3);
        checkOutput("mg_done_count", 32'(doneCount), 32'd1);

        // Request in the POST beat goes straight to PRE
        applyStimulus(1'b1, 6'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        tick();
        tick();
        checkOutput("pp_post_done", 32'(if1.done), 32'h1);
        checkOutput("pp_post_ready", 32'(if1.req_ready), 32'h1);
        applyStimulus(1'b1, 6'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("pp_pre_t", 32'(if1.t), 32'h8);
        checkOutput("pp_pre_busy", 32'(if1.busy), 32'h1);
        checkOutput("pp_pre_done", 32'(if1.done), 32'h0);
        tick();
        tick();
        tick();
        checkOutput("pp_idle_t", 32'(if1.t), 32'h0);

        // Flush in the 2nd of 5 BURST beats
        burstBeats = 0;
        applyStimulus(1'b1, 6'd5, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 6'd1, 1'b1);
        #1;
        checkOutput("fl_ready_blocked", 32'(if1.req_ready), 32'h0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        checkOutput("fl_post_t", 32'(if1.t), 32'h1);
        checkOutput("fl_post_done", 32'(if1.done), 32'h1);
        tick();
        checkOutput("fl_idle_t", 32'(if1.t), 32'h0);
        checkOutput("fl_idle_busy", 32'(if1.busy), 32'h0);
        checkOutput("fl_beats", 32'(burstBeats), 32'd2);

        // req_len = 0 behaves as one burst
        burstBeats = 0;
        applyStimulus(1'b1, 6'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        tick();
        checkOutput("z_burst_ready", 32'(if1.req_ready), 32'h1);
        tick();
        checkOutput("z_post_t", 32'(if1.t), 32'h1);
        tick();
        checkOutput("z_beats", 32'(burstBeats), 32'd1);

        // Maximum length: 63 BURST beats, one POST
        burstBeats = 0;
        doneCount  = 0;
        applyStimulus(1'b1, 6'd63, 1'b0);
        tick();
        applyStimulus(1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 100 && if1.busy === 1'b1; i++) begin
            tick();
        end
        checkOutput("max_beats", 32'(burstBeats), 32'd63);
        checkOutput("max_done_count", 32'(doneCount), 32'd1);
        checkOutput("max_idle", 32'(if1.busy), 32'h0);

        // Two-slot instance: wider masks and asynchronous reset mid-train
        if2.req_valid = 1'b1;
        if2.req_len   = 6'd4;
        tick();
        if2.req_valid = 1'b0;
        if2.req_len   = 6'd0;
        checkOutput("w2_pre_t", 32'(if2.t), 32'hC);
        tick();
        tick();
        checkOutput("w2_burst_t", 32'(if2.t), 32'hF);
        #2;
        rst2_n = 1'b0;
        #1;
        checkOutput("w2_async_t", 32'(if2.t), 32'h0);
        checkOutput("w2_async_busy", 32'(if2.busy), 32'h0);
        #2;
        rst2_n = 1'b1;
        tick();
        checkOutput("w2_after_t", 32'(if2.t), 32'h0);
        checkOutput("w2_after_busy", 32'(if2.busy), 32'h0);
        checkOutput("w2_after_ready", 32'(if2.req_ready), 32'h1);
        if2.req_valid = 1'b1;
        if2.req_len   = 6'd1;
        tick();
        if2.req_valid = 1'b0;
        checkOutput("w2_pre2_t", 32'(if2.t), 32'hC);
        tick();
        tick();
        checkOutput("w2_post_t", 32'(if2.t), 32'h3);
        checkOutput("w2_post_done", 32'(if2.done), 32'h1);
        tick();
        checkOutput("w2_idle_t", 32'(if2.t), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
